// File: rtl/puf_ctrl_pkg.sv
// Shared types and constants for the ring-oscillator PUF evaluation controller.
package puf_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam int N_BITS      = 8;
  localparam int SETTLE_CYC  = 2;
  localparam int PAIR_OFF_LO = 1;
  localparam int PAIR_OFF_HI = 4;

  // Partner oscillator for bit idx; 3-bit addition wraps modulo 8, and both offsets are nonzero.
  function automatic logic [2:0] pair_sel(input logic [2:0] idx, input logic chal_bit);
    pair_sel = idx + (chal_bit ? 3'(PAIR_OFF_HI) : 3'(PAIR_OFF_LO));
  endfunction

endpackage

// File: rtl/puf_eval_ctrl_window_timer.sv
// Loadable down-counter with a zero flag; times the RUN gate window and the SETTLE gap.
module window_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/puf_eval_ctrl.sv
// Ring-oscillator PUF controller: for each challenge bit, gates an oscillator pair for a
// fixed window, lets the counters settle, and records which oscillator ran faster.
module puf_eval_ctrl
  import puf_ctrl_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       challenge,
  input  logic [CNT_W-1:0] count_a,
  input  logic [CNT_W-1:0] count_b,
  output logic             osc_en,
  output logic             cnt_clr,
  output logic [2:0]       sel_a,
  output logic [2:0]       sel_b,
  output logic             busy,
  output logic             done,
  output logic [7:0]       response,
  output logic             ovf
);

  state_t     state, nxt;
  logic [2:0] idx;
  logic [7:0] chal, shadow, shadow_nxt;
  logic       t_load, t_zero;
  logic [7:0] t_val;
  logic       cmp_gt, last_bit;

  window_timer #(.W(8)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  assign cmp_gt   = (count_a > count_b);
  assign last_bit = (idx == 3'(N_BITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (start) nxt = S_CLEAR;
      S_CLEAR:   nxt = S_RUN;
      S_RUN:     if (t_zero) nxt = S_SETTLE;
      S_SETTLE:  if (t_zero) nxt = S_COMPARE;
      S_COMPARE: nxt = last_bit ? S_DONE : S_CLEAR;
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // Timer is loaded one cycle ahead so RUN lasts WINDOW cycles and SETTLE lasts SETTLE_CYC.
  always_comb begin
    osc_en  = (state == S_RUN);
    cnt_clr = reset || (state == S_CLEAR);
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    sel_a   = '0;
    sel_b   = '0;
    t_load  = 1'b0;
    t_val   = 8'(WINDOW - 1);
    if (state != S_IDLE) begin
      sel_a = idx;
      sel_b = pair_sel(idx, chal[idx]);
    end
    if (state == S_CLEAR) begin
      t_load = 1'b1;
    end else if (state == S_RUN && t_zero) begin
      t_load = 1'b1;
      t_val  = 8'(SETTLE_CYC - 1);
    end
  end

  always_comb begin
    shadow_nxt      = shadow;
    shadow_nxt[idx] = cmp_gt;
  end

  // response is updated on the edge into DONE so it is already valid while done is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      chal     <= '0;
      shadow   <= '0;
      response <= '0;
      ovf      <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        chal   <= challenge;
        idx    <= '0;
        shadow <= '0;
        ovf    <= 1'b0;
      end
      if (state == S_COMPARE) begin
        shadow <= shadow_nxt;
        if (count_a == '1 || count_b == '1) ovf <= 1'b1;
        if (last_bit) response <= shadow_nxt;
        else          idx      <= idx + 1'b1;
      end
    end
  end

endmodule
